// File: rtl/writeback_queue_pkg.sv
// Shared widths and queue entry type for the register-file writeback path.
package writeback_queue_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_match.sv
// Combinational youngest-first search over pending writebacks.
// Slot 0 is the oldest entry and slot N-1 the youngest.
module wb_match
  import writeback_queue_pkg::*;
#(
  parameter int N = 5
) (
  input  wb_entry_t [N-1:0]   entries,
  input  logic      [N-1:0]   valid,
  input  logic [ADDR_W-1:0]   addr,
  output logic                hit,
  output logic [DATA_W-1:0]   fwd
);

  // Later matches overwrite earlier ones, so the youngest match wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (entries[i].rd == addr) && (addr != '0)) begin
        hit = 1'b1;
        fwd = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue merging ALU and load results onto the single
// register-file write port, with rs/rt bypass lookup of pending values.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_hit,
  output logic [DATA_W-1:0] rs_fwd,
  output logic              rt_hit,
  output logic [DATA_W-1:0] rt_fwd,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_M1 = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_M2 = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  wb_entry_t [DEPTH-1:0]  entries_q, entries_d;
  logic                   rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]      rf_rd_addr_q, rf_rd_addr_d;
  logic [DATA_W-1:0]      rf_data_in_q, rf_data_in_d;

  logic mem_push;
  logic alu_push;
  logic pop;

  // Ready looks only at the registered count; a pop this cycle earns no credit.
  assign mem_ready = (count_q <= CNT_M1);
  assign alu_ready = (count_q <= CNT_M2) || ((count_q == CNT_M1) && !mem_valid);

  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign pop      = (count_q != '0);

  always_comb begin
    entries_d    = entries_q;
    head_d       = head_q;
    tail_d       = tail_q;
    rf_write_d   = pop;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_data_in_d = rf_data_in_q;
    if (pop) begin
      rf_rd_addr_d = entries_q[head_q].rd;
      rf_data_in_d = entries_q[head_q].data;
      head_d       = head_q + 1'b1;
    end
    // The load result is older than the ALU result when both arrive together.
    if (mem_push) begin
      entries_d[tail_d] = wb_entry_t'{rd: mem_rd, data: mem_data};
      tail_d            = tail_d + 1'b1;
    end
    if (alu_push) begin
      entries_d[tail_d] = wb_entry_t'{rd: alu_rd, data: alu_data};
      tail_d            = tail_d + 1'b1;
    end
    count_d = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rf_write_q   <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_data_in_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rf_write_q   <= rf_write_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_data_in_q <= rf_data_in_d;
    end
  end

  always_ff @(posedge clock) begin
    entries_q <= entries_d;
  end

  wb_entry_t [DEPTH:0] search;
  logic      [DEPTH:0] search_valid;

  // Age order for the search: output register first, then queue head to tail.
  always_comb begin
    search[0]       = wb_entry_t'{rd: rf_rd_addr_q, data: rf_data_in_q};
    search_valid[0] = rf_write_q;
    for (int i = 0; i < DEPTH; i++) begin
      search[i+1]       = entries_q[head_q + PTR_W'(i)];
      search_valid[i+1] = (CNT_W'(i) < count_q);
    end
  end

  wb_match #(.N(DEPTH + 1)) u_rs_match (
    .entries (search),
    .valid   (search_valid),
    .addr    (rs_addr),
    .hit     (rs_hit),
    .fwd     (rs_fwd)
  );

  wb_match #(.N(DEPTH + 1)) u_rt_match (
    .entries (search),
    .valid   (search_valid),
    .addr    (rt_addr),
    .hit     (rt_hit),
    .fwd     (rt_fwd)
  );

  assign rf_write   = rf_write_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_data_in = rf_data_in_q;
  assign idle       = (count_q == '0) && !rf_write_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: scoreboard of expected register
// writes plus a count model for ready/idle and a pending-set bypass model.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_data_in;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_hit;
  logic [DATA_W-1:0] rs_fwd;
  logic              rt_hit;
  logic [DATA_W-1:0] rt_fwd;
  logic              idle;

  int        checks = 0;
  int        failures = 0;
  wb_entry_t sb[$];
  int        model_count = 0;
  bit        model_rf_write = 1'b0;

  always #5 clock = ~clock;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .rf_write   (rf_write),
    .rf_rd_addr (rf_rd_addr),
    .rf_data_in (rf_data_in),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_hit     (rs_hit),
    .rs_fwd     (rs_fwd),
    .rt_hit     (rt_hit),
    .rt_fwd     (rt_fwd),
    .idle       (idle)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Pending set is exactly the scoreboard contents: youngest match wins.
  function automatic void modelBypass(input logic [ADDR_W-1:0] addr, output bit hit, output logic [31:0] fwd);
    hit = 1'b0;
    fwd = '0;
    if (addr != '0) begin
      foreach (sb[i]) begin
        if (sb[i].rd == addr) begin
          hit = 1'b1;
          fwd = sb[i].data;
        end
      end
    end
  endfunction

  // Every register-file write must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && rf_write) begin
      checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wb_entry_t e;
        e = sb.pop_front();
        checkOutput("sb_rd", 32'(rf_rd_addr), 32'(e.rd));
        checkOutput("sb_data", rf_data_in, e.data);
      end
    end
  end

  task automatic applyStimulus(input bit av, input logic [ADDR_W-1:0] ard, input logic [31:0] ad,
                               input bit mv, input logic [ADDR_W-1:0] mrd, input logic [31:0] md,
                               output bit acc_a, output bit acc_m);
    bit          exp_mr, exp_ar, hit;
    logic [31:0] fwd;
    int          pushes;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    #1;
    exp_mr = (model_count <= DEPTH - 1);
    exp_ar = (model_count <= DEPTH - 2) || (model_count == DEPTH - 1 && !mv);
    checkOutput("mem_ready", 32'(mem_ready), 32'(exp_mr));
    checkOutput("alu_ready", 32'(alu_ready), 32'(exp_ar));
    acc_m  = mv && exp_mr;
    acc_a  = av && exp_ar;
    pushes = 0;
    if (acc_m && mrd != '0) begin
      sb.push_back(wb_entry_t'{rd: mrd, data: md});
      pushes++;
    end
    if (acc_a && ard != '0) begin
      sb.push_back(wb_entry_t'{rd: ard, data: ad});
      pushes++;
    end
    @(posedge clock);
    model_rf_write = (model_count > 0);
    model_count    = model_count + pushes - (model_count > 0 ? 1 : 0);
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    checkOutput("rf_write", 32'(rf_write), 32'(model_rf_write));
    checkOutput("idle", 32'(idle), 32'(model_count == 0 && !model_rf_write));
    modelBypass(rs_addr, hit, fwd);
    checkOutput("rs_hit", 32'(rs_hit), 32'(hit));
    checkOutput("rs_fwd", rs_fwd, fwd);
    modelBypass(rt_addr, hit, fwd);
    checkOutput("rt_hit", 32'(rt_hit), 32'(hit));
    checkOutput("rt_fwd", rt_fwd, fwd);
  endtask

  task automatic idleStep();
    bit a, m;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, a, m);
  endtask

  initial begin
    bit a, m;
    int mi, ai;
    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;
    rs_addr   = '0;
    rt_addr   = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_rf_write", 32'(rf_write), 32'd0);
    checkOutput("reset_rf_rd_addr", 32'(rf_rd_addr), 32'd0);
    checkOutput("reset_rf_data_in", rf_data_in, 32'd0);
    checkOutput("reset_idle", 32'(idle), 32'd1);
    checkOutput("reset_rs_hit", 32'(rs_hit), 32'd0);
    reset = 1'b0;

    // Single ALU write: visible on rf_* one edge after acceptance.
    rs_addr = 6'd5;
    applyStimulus(1'b1, 6'd5, 32'h13, 1'b0, '0, '0, a, m);
    checkOutput("t1_no_write_yet", 32'(rf_write), 32'd0);
    checkOutput("t1_rs_hit", 32'(rs_hit), 32'd1);
    idleStep();
    checkOutput("t1_rf_write", 32'(rf_write), 32'd1);
    checkOutput("t1_rf_rd_addr", 32'(rf_rd_addr), 32'd5);
    checkOutput("t1_rf_data_in", rf_data_in, 32'h13);
    idleStep();
    checkOutput("t1_rf_write_done", 32'(rf_write), 32'd0);
    checkOutput("t1_idle", 32'(idle), 32'd1);

    // Simultaneous mem and alu to the same register: mem is older.
    rs_addr = 6'd3;
    applyStimulus(1'b1, 6'd3, 32'hBB, 1'b1, 6'd3, 32'hAA, a, m);
    checkOutput("t2_rs_hit", 32'(rs_hit), 32'd1);
    checkOutput("t2_rs_fwd", rs_fwd, 32'hBB);
    idleStep();
    checkOutput("t2_first_data", rf_data_in, 32'hAA);
    checkOutput("t2_rs_fwd_mid", rs_fwd, 32'hBB);
    idleStep();
    checkOutput("t2_second_data", rf_data_in, 32'hBB);
    idleStep();

    // Writes to register 0 are accepted and dropped.
    rs_addr = 6'd0;
    applyStimulus(1'b1, 6'd0, 32'hFFFF, 1'b0, '0, '0, a, m);
    checkOutput("t3_rs_hit", 32'(rs_hit), 32'd0);
    checkOutput("t3_idle", 32'(idle), 32'd1);
    repeat (2) idleStep();

    // Continuous stream from both producers, backpressure at thresholds.
    rs_addr = 6'd4;
    rt_addr = 6'd7;
    mi = 0;
    ai = 0;
    for (int s = 0; s < 40 && (mi < 4 || ai < 4); s++) begin
      logic [ADDR_W-1:0] mrd, ard;
      mrd = ADDR_W'(2 * mi + 1);
      ard = ADDR_W'(2 * ai + 2);
      applyStimulus(ai < 4, ard, 32'h100 + 32'(ard), mi < 4, mrd, 32'h100 + 32'(mrd), a, m);
      if (m) mi++;
      if (a) ai++;
    end
    checkOutput("stream_all_sent", 32'(mi + ai), 32'd8);
    repeat (DEPTH + 2) idleStep();
    checkOutput("stream_drained", 32'(sb.size()), 32'd0);

    // Reset with three entries queued: everything in flight is lost.
    rs_addr = 6'd12;
    applyStimulus(1'b1, 6'd10, 32'h100, 1'b1, 6'd9, 32'h99, a, m);
    applyStimulus(1'b1, 6'd12, 32'h120, 1'b1, 6'd11, 32'h110, a, m);
    checkOutput("t5_busy", 32'(idle), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("t5_rf_write_async", 32'(rf_write), 32'd0);
    checkOutput("t5_idle_async", 32'(idle), 32'd1);
    checkOutput("t5_rs_hit_async", 32'(rs_hit), 32'd0);
    sb.delete();
    model_count    = 0;
    model_rf_write = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) idleStep();

    // Queued rd=7 is younger than rd=7 sitting in the output register.
    rs_addr = 6'd0;
    rt_addr = 6'd7;
    applyStimulus(1'b1, 6'd7, 32'h11, 1'b0, '0, '0, a, m);
    applyStimulus(1'b1, 6'd7, 32'h22, 1'b0, '0, '0, a, m);
    checkOutput("t6_rf_rd_addr", 32'(rf_rd_addr), 32'd7);
    checkOutput("t6_rf_data_in", rf_data_in, 32'h11);
    checkOutput("t6_rt_hit", 32'(rt_hit), 32'd1);
    checkOutput("t6_rt_fwd", rt_fwd, 32'h22);
    repeat (2) idleStep();
    checkOutput("t6_rt_hit_after", 32'(rt_hit), 32'd0);

    checkOutput("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
